// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered round-robin arbiter with a valid/ready grant handshake
// Ports:
//   clock       - rising-edge clock
//   resetn      - asynchronous active-low reset
//   requests    - request vector, bit i set when requester i wants service
//   grant       - registered one-hot grant, zero whenever grant_valid is low
//   grant_valid - grant holds a winner awaiting acceptance
//   grant_ready - downstream accepts the current grant this cycle
module round_robin_arbiter #(
    parameter int WIDTH         = 4,
    parameter int WIDTH_POINTER = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] requests,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    input  logic             grant_ready
);
    logic [WIDTH_POINTER-1:0] pointer_q, pointer_d, win_idx, idx;
    logic [WIDTH-1:0]         grant_q, grant_d;
    logic                     grant_valid_q, grant_valid_d, found, load;
    // Scan from the pointer upward with explicit modulo wrap; the first set bit wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = WIDTH_POINTER'((int'(pointer_q) + k) % WIDTH);
            if (!found && requests[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end
    // A pending grant is sticky: the register only reloads when empty or accepted.
    assign load          = !grant_valid_q || grant_ready;
    assign grant_valid_d = load ? found : grant_valid_q;
    assign grant_d       = load ? (found ? (WIDTH'(1) << win_idx) : '0) : grant_q;
    assign pointer_d     = (load && found)
                         ? ((win_idx == WIDTH_POINTER'(WIDTH - 1)) ? '0 : win_idx + WIDTH_POINTER'(1))
                         : pointer_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pointer_q     <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            pointer_q     <= pointer_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
        end
    end
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: scoreboard bench for round_robin_arbiter at WIDTH 4 and WIDTH 3
module tb_round_robin_arbiter;
    logic       clk = 1'b0;
    logic       rst4_n = 1'b0, rst3_n = 1'b0;
    logic [3:0] req4 = '0, g4;
    logic [2:0] req3 = '0, g3;
    logic       rdy4 = 1'b0, rdy3 = 1'b0, gv4, gv3;
    int         n_chk = 0, n_fail = 0;

    typedef struct {
        int ptr;
        bit gv;
        int gi;
    } st_t;

    st_t        s4, s3;
    logic [4:0] q4[$], q3[$];

    always #5 clk = ~clk;

    round_robin_arbiter #(.WIDTH(4)) dut4 (
        .clock(clk), .resetn(rst4_n), .requests(req4),
        .grant(g4), .grant_valid(gv4), .grant_ready(rdy4));

    round_robin_arbiter #(.WIDTH(3)) dut3 (
        .clock(clk), .resetn(rst3_n), .requests(req3),
        .grant(g3), .grant_valid(gv3), .grant_ready(rdy3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act[7:0], exp[7:0], $time);
        end
    endtask

    // Reference behaviour: the grant register is either idle, holding an unaccepted
    // winner, or replaced by the first requester found going round from the priority index.
    function automatic st_t nxt(st_t s, int w, logic [3:0] r, logic rd, logic rn);
        st_t n = s;
        if (!rn) begin
            n.ptr = 0; n.gv = 0; n.gi = -1;
        end else if (!s.gv || rd) begin
            n.gi = -1;
            for (int k = 0; k < w; k++)
                if (n.gi < 0 && r[(s.ptr + k) % w]) n.gi = (s.ptr + k) % w;
            n.gv = (n.gi >= 0);
            if (n.gv) n.ptr = (n.gi + 1) % w;
        end
        return n;
    endfunction

    function automatic logic [4:0] exp_of(st_t s);
        logic [3:0] oh = '0;
        if (s.gv) oh[s.gi] = 1'b1;
        return {s.gv, oh};
    endfunction

    task automatic cyc4(input logic [3:0] r, input logic rd, input logic rn);
        @(negedge clk);
        req4 = r; rdy4 = rd; rst4_n = rn;
        s4 = nxt(s4, 4, r, rd, rn);
        q4.push_back(exp_of(s4));
    endtask

    task automatic cyc3(input logic [2:0] r, input logic rd, input logic rn);
        @(negedge clk);
        req3 = r; rdy3 = rd; rst3_n = rn;
        s3 = nxt(s3, 3, {1'b0, r}, rd, rn);
        q3.push_back(exp_of(s3));
    endtask

    task automatic stim4();
        repeat (2) cyc4(4'b0000, 1'b0, 1'b0);
        chk("reset_grant4", {gv4, g4}, 5'b0);
        repeat (5) cyc4(4'b1111, 1'b1, 1'b1);
        cyc4(4'b0000, 1'b1, 1'b1);
        cyc4(4'b0110, 1'b1, 1'b1);
        repeat (3) cyc4(4'b0110, 1'b0, 1'b1);
        cyc4(4'b0110, 1'b1, 1'b1);
        repeat (2) cyc4(4'b0000, 1'b0, 1'b1);
        cyc4(4'b0000, 1'b1, 1'b1);
        repeat (2) cyc4(4'b0011, 1'b1, 1'b1);
        cyc4(4'b1000, 1'b1, 1'b1);
        cyc4(4'b1000, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst4_n = 1'b0;
        #1 chk("async_reset4", {gv4, g4}, 5'b0);
        s4 = nxt(s4, 4, 4'b0, 1'b0, 1'b0);
        cyc4(4'b1001, 1'b0, 1'b0);
        cyc4(4'b1001, 1'b1, 1'b1);
        repeat (300) cyc4(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b1);
    endtask

    task automatic stim3();
        repeat (2) cyc3(3'b000, 1'b0, 1'b0);
        repeat (4) cyc3(3'b111, 1'b1, 1'b1);
        repeat (300) cyc3(3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0), 1'b1);
    endtask

    initial begin : mon4
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("grant4", {gv4, g4}, e);
                chk("onehot4", $onehot0(g4), 1);
            end
        end
    end

    initial begin : mon3
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("grant3", {gv3, 1'b0, g3}, e);
                chk("ptr3_range", dut3.pointer_q <= 2'd2, 1);
            end
        end
    end

    initial begin
        s4 = '{ptr: 0, gv: 0, gi: -1};
        s3 = '{ptr: 0, gv: 0, gi: -1};
        fork
            stim4();
            stim3();
        join
        repeat (2) @(posedge clk);
        #2;
        chk("drain4", q4.size(), 0);
        chk("drain3", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
